dds_sweep_bank: RTL

Parametrised multi-channel DDS control bank for the ultrasonic front end. It holds a register file written over the host bus and runs NCH phase accumulators, each with an optional linear frequency sweep (start/step/stop, loop or hold). It emits per-channel phase indices for the sine ROM/DAC path and a programmable sample-strobe for the ADC capture logic.

---
 rtl/dds_pkg.sv | 35 +++
 rtl/dds_sweep_bank_if.sv | 10 +
 rtl/dds_sweep_chan.sv | 68 ++++++
 rtl/dds_sweep_bank.sv | 133 +++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - register map offsets, control bit positions and reset values
// Shared by the DDS sweep bank top and its per-channel engine.
package dds_pkg;

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_FSTART_H = 3'd1;
  localparam logic [2:0] OFF_FSTART_L = 3'd2;
  localparam logic [2:0] OFF_FSTEP_H  = 3'd3;
  localparam logic [2:0] OFF_FSTEP_L  = 3'd4;
  localparam logic [2:0] OFF_FSTOP_H  = 3'd5;
  localparam logic [2:0] OFF_FSTOP_L  = 3'd6;
  localparam logic [2:0] OFF_PWORD    = 3'd7;

  localparam logic [2:0] OFF_DWELL_H   = 3'd0;
  localparam logic [2:0] OFF_DWELL_L   = 3'd1;
  localparam logic [2:0] OFF_SMAX_H    = 3'd2;
  localparam logic [2:0] OFF_SMAX_L    = 3'd3;
  localparam logic [2:0] OFF_SAMPLE_EN = 3'd4;
  localparam logic [2:0] OFF_SYNC      = 3'd5;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_SWEEP = 1;
  localparam int CTRL_LOOP  = 2;

  localparam logic [2:0]  RST_CTRL = 3'b001;
  localparam logic [31:0] RST_FREQ = 32'h0083_12B0;
  localparam logic [31:0] RST_SMAX = 32'd5;

  // Update one 16-bit half of a 32-bit register image.
  function automatic logic [31:0] wr_half(input logic [31:0] cur, input logic hi,
                                          input logic [15:0] d);
    return hi ? {d, cur[15:0]} : {cur[31:16], d};
  endfunction

endpackage

// File: rtl/dds_sweep_bank_if.sv
// rtl/dds_sweep_bank_if.sv - host register write bus for the DDS sweep bank
// Single-cycle write strobe with address and data.
interface dds_sweep_bank_if;
  logic        m_wr;
  logic [7:0]  m_addr;
  logic [15:0] m_wrdata;

  modport master (output m_wr, output m_addr, output m_wrdata);
  modport slave  (input  m_wr, input  m_addr, input  m_wrdata);
endinterface

// File: rtl/dds_sweep_chan.sv
// rtl/dds_sweep_chan.sv - one DDS channel: current frequency word, sweep step/clamp,
// phase accumulator and registered phase index output.
module dds_sweep_chan
  import dds_pkg::*;
#(
  parameter int ACC_W   = 32,
  parameter int PHASE_W = 12
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic               i_sweep_en,
  input  logic               i_loop,
  input  logic               i_restart,
  input  logic               i_sync,
  input  logic               i_tick,
  input  logic [ACC_W-1:0]   i_fstart,
  input  logic [ACC_W-1:0]   i_fstep,
  input  logic [ACC_W-1:0]   i_fstop,
  input  logic [PHASE_W-1:0] i_pword,
  output logic [PHASE_W-1:0] o_phase,
  output logic               o_done
);

  logic [ACC_W-1:0]   r_fcur;
  logic [ACC_W-1:0]   r_acc;
  logic [PHASE_W-1:0] r_phase;
  logic               r_done;
  logic [ACC_W:0]     w_nxt;

  // One extra bit so a step past 2^ACC_W clamps instead of wrapping.
  assign w_nxt = {1'b0, r_fcur} + {1'b0, i_fstep};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fcur  <= '0;
      r_acc   <= '0;
      r_phase <= '0;
      r_done  <= 1'b0;
    end else begin
      if (i_restart) begin
        r_fcur <= i_fstart;
        r_done <= 1'b0;
      end else if (!i_sweep_en) begin
        r_fcur <= i_fstart;
      end else if (i_tick && !r_done) begin
        if (w_nxt <= {1'b0, i_fstop}) begin
          r_fcur <= w_nxt[ACC_W-1:0];
        end else if (i_loop) begin
          r_fcur <= i_fstart;
        end else begin
          r_fcur <= i_fstop;
          r_done <= 1'b1;
        end
      end

      if (i_sync)    r_acc <= '0;
      else if (i_en) r_acc <= r_acc + r_fcur;
      else           r_acc <= '0;

      r_phase <= i_en ? r_acc[ACC_W-1 -: PHASE_W] + i_pword : '0;
    end
  end

  assign o_phase = r_phase;
  assign o_done  = r_done;

endmodule

// File: rtl/dds_sweep_bank.sv
// rtl/dds_sweep_bank.sv - multi-channel DDS control bank: register file, shared dwell
// counter, SYNC strobe and ADC sample strobe generator.
module dds_sweep_bank
  import dds_pkg::*;
#(
  parameter int         NCH      = 2,
  parameter int         ACC_W    = 32,
  parameter int         PHASE_W  = 12,
  parameter logic [7:0] CH_BASE  = 8'd16,
  parameter logic [7:0] GBL_BASE = 8'd8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  dds_sweep_bank_if.slave        bus,
  output logic [NCH*PHASE_W-1:0] o_phase,
  output logic [NCH-1:0]         o_ch_en,
  output logic [NCH-1:0]         o_sweep_done,
  output logic                   o_sample_flag
);

  logic [2:0]         r_ctrl   [NCH];
  logic [31:0]        r_fstart [NCH];
  logic [31:0]        r_fstep  [NCH];
  logic [31:0]        r_fstop  [NCH];
  logic [PHASE_W-1:0] r_pword  [NCH];
  logic [NCH-1:0]     r_sweep_d;
  logic [31:0]        r_dwell, r_smax, r_dwell_cnt, r_smp_cnt;
  logic               r_sample_en, r_sample_flag;

  logic [NCH-1:0]     w_ch_wr, w_restart;
  logic               w_gbl_wr, w_sync, w_tick;

  // Blocks are 8-aligned, so the upper five address bits select the block.
  always_comb begin
    w_gbl_wr  = bus.m_wr && (bus.m_addr[7:3] == GBL_BASE[7:3]);
    w_sync    = w_gbl_wr && (bus.m_addr[2:0] == OFF_SYNC);
    w_ch_wr   = '0;
    w_restart = '0;
    for (int c = 0; c < NCH; c++) begin
      w_ch_wr[c]   = bus.m_wr && (bus.m_addr[7:3] == 5'(int'(CH_BASE[7:3]) + c));
      w_restart[c] = w_sync || (r_ctrl[c][CTRL_SWEEP] && !r_sweep_d[c]);
    end
    w_tick = !(|w_restart) && (r_dwell_cnt >= r_dwell);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        r_ctrl[c]   <= RST_CTRL;
        r_fstart[c] <= RST_FREQ;
        r_fstep[c]  <= '0;
        r_fstop[c]  <= RST_FREQ;
        r_pword[c]  <= '0;
      end
      r_sweep_d   <= '0;
      r_dwell     <= '0;
      r_smax      <= RST_SMAX;
      r_sample_en <= 1'b0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        r_sweep_d[c] <= r_ctrl[c][CTRL_SWEEP];
        if (w_ch_wr[c]) begin
          case (bus.m_addr[2:0])
            OFF_CTRL:     r_ctrl[c]   <= bus.m_wrdata[2:0];
            OFF_FSTART_H: r_fstart[c] <= wr_half(r_fstart[c], 1'b1, bus.m_wrdata);
            OFF_FSTART_L: r_fstart[c] <= wr_half(r_fstart[c], 1'b0, bus.m_wrdata);
            OFF_FSTEP_H:  r_fstep[c]  <= wr_half(r_fstep[c], 1'b1, bus.m_wrdata);
            OFF_FSTEP_L:  r_fstep[c]  <= wr_half(r_fstep[c], 1'b0, bus.m_wrdata);
            OFF_FSTOP_H:  r_fstop[c]  <= wr_half(r_fstop[c], 1'b1, bus.m_wrdata);
            OFF_FSTOP_L:  r_fstop[c]  <= wr_half(r_fstop[c], 1'b0, bus.m_wrdata);
            OFF_PWORD:    r_pword[c]  <= bus.m_wrdata[PHASE_W-1:0];
          endcase
        end
      end
      if (w_gbl_wr) begin
        case (bus.m_addr[2:0])
          OFF_DWELL_H:   r_dwell     <= wr_half(r_dwell, 1'b1, bus.m_wrdata);
          OFF_DWELL_L:   r_dwell     <= wr_half(r_dwell, 1'b0, bus.m_wrdata);
          OFF_SMAX_H:    r_smax      <= wr_half(r_smax, 1'b1, bus.m_wrdata);
          OFF_SMAX_L:    r_smax      <= wr_half(r_smax, 1'b0, bus.m_wrdata);
          OFF_SAMPLE_EN: r_sample_en <= bus.m_wrdata[0];
          default: ;
        endcase
      end
    end
  end

  // >= rather than == keeps both counters bounded if a limit shrinks mid-count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dwell_cnt   <= '0;
      r_smp_cnt     <= '0;
      r_sample_flag <= 1'b0;
    end else begin
      if ((|w_restart) || (r_dwell_cnt >= r_dwell)) r_dwell_cnt <= '0;
      else                                          r_dwell_cnt <= r_dwell_cnt + 32'd1;

      if (!r_sample_en) begin
        r_smp_cnt     <= '0;
        r_sample_flag <= 1'b0;
      end else begin
        r_sample_flag <= (r_smp_cnt >= r_smax);
        r_smp_cnt     <= (r_smp_cnt >= r_smax) ? 32'd0 : r_smp_cnt + 32'd1;
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    dds_sweep_chan #(
      .ACC_W   (ACC_W),
      .PHASE_W (PHASE_W)
    ) u_chan (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_en       (r_ctrl[c][CTRL_EN]),
      .i_sweep_en (r_ctrl[c][CTRL_SWEEP]),
      .i_loop     (r_ctrl[c][CTRL_LOOP]),
      .i_restart  (w_restart[c]),
      .i_sync     (w_sync),
      .i_tick     (w_tick),
      .i_fstart   (r_fstart[c][ACC_W-1:0]),
      .i_fstep    (r_fstep[c][ACC_W-1:0]),
      .i_fstop    (r_fstop[c][ACC_W-1:0]),
      .i_pword    (r_pword[c]),
      .o_phase    (o_phase[c*PHASE_W +: PHASE_W]),
      .o_done     (o_sweep_done[c])
    );
    assign o_ch_en[c] = r_ctrl[c][CTRL_EN];
  end

  assign o_sample_flag = r_sample_flag;

endmodule
